// File: rtl/key_pio_in_if.sv
// Avalon-MM slave port of the key/switch PIO: register access plus the level interrupt.
interface key_pio_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/key_pio_in.sv
// Debounced input PIO for keys/switches: per-pin synchronizer and debounce,
// rising-edge capture with write-1-to-clear, maskable level interrupt.
module key_pio_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    key_pio_in_if.slave      bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    // The cycle on which the candidate is latched counts as its first stable cycle,
    // so the debounced bit updates once the counter is about to reach DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] deb_prev_q, deb_prev_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic             wr_en;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] rise;
    logic             unused_wdata;

    assign unused_wdata = ^bus.writedata;

    always_comb begin
        sync1_d = in_port;
        sync2_d = sync1_q;
        cand_d  = sync2_q;
        deb_d   = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] != cand_q[i]) begin
                cnt_d[i] = '0;
            end else begin
                if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_W'(1);
                if (cnt_q[i] >= CNT_HIT) deb_d[i] = cand_q[i];
            end
        end

        deb_prev_d = deb_q;
        rise       = deb_q & ~deb_prev_q;

        wr_en     = bus.chipselect & ~bus.write_n;
        clr       = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
        // A capture arriving in the same cycle as its clear must survive.
        edgecap_d = (edgecap_q & ~clr) | rise;
        mask_d    = (wr_en && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : mask_q;
        irq_d     = |(edgecap_q & mask_q);

        readdata_d = '0;
        if (bus.chipselect) begin
            case (bus.address)
                2'd0:    readdata_d[WIDTH-1:0] = deb_q;
                2'd2:    readdata_d[WIDTH-1:0] = mask_q;
                2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
                default: readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            cand_q     <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            edgecap_q  <= '0;
            mask_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cand_q     <= cand_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            edgecap_q  <= edgecap_d;
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_key_pio_in.sv
// Directed bench for key_pio_in (WIDTH=4, DEBOUNCE_CYCLES=16); inputs change and
// outputs are sampled 1ns after each rising clock edge.
module tb_key_pio_in;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] in_port;
    int         checks = 0;
    int         errors = 0;

    key_pio_in_if bus();

    key_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Read has latency 1: value is sampled after the edge that registers it.
    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        tick();
        chk(tag, bus.readdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        tick();
        bus.write_n    = 1'b1;
        bus.chipselect = 1'b0;
        bus.writedata  = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n        = 1'b1;
        in_port        = 4'h0;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        #3 reset_n = 1'b0;
        #1;
        chk("reset_readdata", bus.readdata, 32'h0);
        chk("reset_irq", {31'b0, bus.irq}, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        rd(2'd0, 32'h0, "rst_addr0");
        rd(2'd2, 32'h0, "rst_addr2");
        rd(2'd3, 32'h0, "rst_addr3");
        chk("rst_irq", {31'b0, bus.irq}, 32'h0);

        // Step on bit 0: debounced at step+18, read one cycle after that.
        in_port = 4'h1;
        bus.address = 2'd0;
        bus.chipselect = 1'b1;
        tick(18);
        chk("deb0_before_latency", bus.readdata, 32'h0);
        tick();
        chk("deb0_at_latency", bus.readdata, 32'h1);
        bus.address = 2'd3;
        tick();
        chk("edge0_set", bus.readdata, 32'h1);
        chk("irq_masked", {31'b0, bus.irq}, 32'h0);
        bus.chipselect = 1'b0;
        tick();
        chk("cs_low_reads_zero", bus.readdata, 32'h0);

        // Glitches on bit 2 of 10 and 15 cycles are rejected.
        in_port = 4'h5;
        tick(10);
        in_port = 4'h1;
        tick(30);
        rd(2'd0, 32'h1, "glitch10_data");
        rd(2'd3, 32'h1, "glitch10_edge");
        chk("glitch10_irq", {31'b0, bus.irq}, 32'h0);
        in_port = 4'h5;
        tick(15);
        in_port = 4'h1;
        tick(30);
        rd(2'd0, 32'h1, "glitch15_data");
        rd(2'd3, 32'h1, "glitch15_edge");

        // A 16-cycle pulse on bit 3 is accepted; its falling edge is not captured.
        in_port = 4'h9;
        tick(16);
        in_port = 4'h1;
        tick(40);
        rd(2'd0, 32'h1, "pulse16_data_after_fall");
        rd(2'd3, 32'h9, "pulse16_edge");
        wr(2'd3, 32'h8);
        rd(2'd3, 32'h1, "w1c_bit3");

        // Mask enables irq one cycle after the mask write.
        wr(2'd2, 32'h1);
        chk("irq_not_yet", {31'b0, bus.irq}, 32'h0);
        tick();
        chk("irq_after_mask", {31'b0, bus.irq}, 32'h1);
        rd(2'd2, 32'h1, "mask_read");
        wr(2'd3, 32'h0);
        rd(2'd3, 32'h1, "w0_no_clear");
        chk("irq_held", {31'b0, bus.irq}, 32'h1);
        rd(2'd3, 32'h1, "read_no_side_effect");
        wr(2'd3, 32'h1);
        chk("irq_still_registered", {31'b0, bus.irq}, 32'h1);
        tick();
        chk("irq_cleared", {31'b0, bus.irq}, 32'h0);
        rd(2'd3, 32'h0, "edge0_cleared");

        // Clear of bit 1 lands on the same edge that captures bit 1's rise.
        in_port = 4'h3;
        tick(18);
        wr(2'd3, 32'h2);
        rd(2'd3, 32'h2, "set_wins_over_clear");
        chk("irq_bit1_unmasked", {31'b0, bus.irq}, 32'h0);
        wr(2'd2, 32'hFFFF_FFF3);
        tick();
        chk("irq_bit1_masked", {31'b0, bus.irq}, 32'h1);
        rd(2'd2, 32'h3, "mask_upper_bits_dropped");
        wr(2'd0, 32'hF);
        wr(2'd1, 32'hF);
        rd(2'd0, 32'h3, "write_addr0_ignored");
        rd(2'd1, 32'h0, "addr1_reads_zero");
        rd(2'd0, 32'h3, "pre_reset_data");

        // Reset mid-debounce with all pins high.
        in_port = 4'hF;
        tick(8);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_readdata", bus.readdata, 32'h0);
        chk("async_reset_irq", {31'b0, bus.irq}, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick(18);
        chk("post_reset_before_latency", bus.readdata, 32'h0);
        tick();
        chk("post_reset_data", bus.readdata, 32'hF);
        bus.address = 2'd3;
        tick();
        chk("post_reset_edge", bus.readdata, 32'hF);
        chk("post_reset_irq", {31'b0, bus.irq}, 32'h0);
        rd(2'd2, 32'h0, "post_reset_mask");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_pio_in.md
KEY_PIO_IN -- requirements
Module: key_pio_in

Interface
REQ-001 Parameter WIDTH, default 4: number of input pins, legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before a pin change is accepted, legal range 2..65535.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 address  input  2  Avalon-MM word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-008 writedata  input  32  write data.
REQ-009 in_port  input  WIDTH  asynchronous external pins (keys, switches).
REQ-010 readdata  output  32  read data; bits above WIDTH-1 read 0.
REQ-011 irq  output  1  active-high level interrupt.

Function
REQ-012 Register map: addr 0 = debounced data (RO); addr 1 = reserved (reads 0, writes ignored); addr 2 = interruptmask (RW, WIDTH bits); addr 3 = edgecapture (read; write-1-to-clear).
REQ-013 Each in_port bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-014 Per-bit debounce: counter clears whenever synchronized value differs from the candidate sample; counter increments while equal; at DEBOUNCE_CYCLES consecutive equal cycles the debounced bit takes the candidate value; counter saturates, no wrap.
REQ-015 Latency: a clean step on in_port appears on the debounced bit exactly 2 + DEBOUNCE_CYCLES cycles later.
REQ-016 Glitches shorter than DEBOUNCE_CYCLES cycles (post-synchronizer) SHALL NOT change the debounced bit.
REQ-017 Edge detect: a debounced bit transition 0->1 sets the matching edgecapture bit one cycle after the transition; 1->0 transitions are ignored.
REQ-018 edgecapture bits are sticky until cleared by a write to address 3 with the matching writedata bit = 1; writedata bits = 0 leave bits unchanged.
REQ-019 Simultaneous set and clear on the same bit in the same cycle: set wins, bit remains 1.
REQ-020 Write to address 2 (chipselect=1, write_n=0) loads interruptmask from writedata[WIDTH-1:0] on that clock edge.
REQ-021 irq SHALL be registered: irq = OR of (edgecapture AND interruptmask), updated one cycle after either operand changes.
REQ-022 readdata SHALL be registered every cycle from the address-selected source (fixed read latency 1); valid the cycle after address is presented with chipselect=1; readdata = 0 when chipselect=0.
REQ-023 Reads SHALL have no side effects; reading edgecapture does not clear it.
REQ-024 Writes to addresses 0 and 1 SHALL have no effect.

Reset
REQ-025 On reset_n low, immediately and independent of clk: synchronizer flops, debounced data, candidate samples, counters, edgecapture, interruptmask, readdata and irq all = 0.
REQ-026 Reset asserted mid-debounce SHALL discard the partial count; after release, a pin held high produces a debounced 1 and an edgecapture set per REQ-015/017.
REQ-027 After reset release the block SHALL accept accesses on the first clock edge.

Verification
REQ-028 Reset, in_port=4'b0000, read addr 0/2/3 -> readdata=0 each, irq=0.
REQ-029 in_port[0] step 0->1, held -> addr 0 reads 0x1 starting 18 cycles after step (DEBOUNCE_CYCLES=16); edgecapture reads 0x1 one cycle later.
REQ-030 in_port[2] 10-cycle high pulse -> addr 0 stays 0, edgecapture stays 0, irq stays 0.
REQ-031 edgecapture=0x1, write addr 2 = 0x1 -> irq=1 two cycles after the write; write addr 3 = 0x1 -> edgecapture=0, irq=0 two cycles later; write addr 3 = 0x0 instead -> no change.
REQ-032 edgecapture clear write of 0x2 in same cycle as new rising edge on bit 1 -> edgecapture[1] remains 1.
REQ-033 Assert reset_n low for 3 cycles mid-debounce with in_port=0xF held -> all outputs 0 asynchronously; after release, addr 0 reads 0xF after 18 cycles and edgecapture=0xF.
